// File: rtl/m3_speed_ramp_calc_pkg.sv
// Shared motor602 definitions: ramp state encodings, step kinds and default
// round-length limits used by the speed ramp calculator.
package m3_speed_ramp_calc_pkg;

  localparam int unsigned M602_PERIOD_MIN = 40;
  localparam int unsigned M602_PERIOD_MAX = 1_000_000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_INC  = 3'd2,
    ST_DEC  = 3'd3,
    ST_SEEK = 3'd4,
    ST_STOP = 3'd5
  } m3_state_e;

  typedef enum logic [1:0] {
    STEP_INC  = 2'd0,
    STEP_DEC  = 2'd1,
    STEP_STOP = 2'd2,
    STEP_SEEK = 2'd3
  } step_kind_e;

endpackage

// File: rtl/m3_speed_ramp_calc_step.sv
// Ramp step arithmetic: shift, floor-to-1, add/sub at W+1 bits, then clamp.
// One instance serves accel, decel, fast-stop and target-seek steps.
module m3_ramp_step
  import m3_speed_ramp_calc_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter int unsigned PERIOD_MIN = M602_PERIOD_MIN,
  parameter int unsigned PERIOD_MAX = M602_PERIOD_MAX,
  parameter int unsigned INC_SHIFT  = 4,
  parameter int unsigned DEC_SHIFT  = 4,
  parameter int unsigned STOP_SHIFT = 2
) (
  input  logic [W-1:0] len_i,
  input  logic [W-1:0] tgt_i,
  input  step_kind_e   kind_i,
  output logic [W-1:0] len_o
);

  localparam logic [W:0] MIN_X = (W+1)'(PERIOD_MIN);
  localparam logic [W:0] MAX_X = (W+1)'(PERIOD_MAX);

  logic         shorten;
  logic [W-1:0] shifted;
  logic [W-1:0] step;
  logic [W:0]   lo_x;
  logic [W:0]   hi_x;
  logic [W:0]   sum_x;
  logic [W:0]   diff_x;

  always_comb begin
    shorten = 1'b0;
    shifted = len_i >> DEC_SHIFT;
    lo_x    = MIN_X;
    hi_x    = MAX_X;
    unique case (kind_i)
      STEP_INC: begin
        shorten = 1'b1;
        shifted = len_i >> INC_SHIFT;
      end
      STEP_DEC:  shifted = len_i >> DEC_SHIFT;
      STEP_STOP: shifted = len_i >> STOP_SHIFT;
      STEP_SEEK: begin
        // The target itself becomes the clamp bound so the seek never overshoots.
        if (tgt_i < len_i) begin
          shorten = 1'b1;
          shifted = len_i >> INC_SHIFT;
          lo_x    = {1'b0, tgt_i};
        end else begin
          shifted = len_i >> DEC_SHIFT;
          hi_x    = {1'b0, tgt_i};
        end
      end
    endcase

    step   = (shifted == '0) ? W'(1) : shifted;
    sum_x  = {1'b0, len_i} + {1'b0, step};
    diff_x = {1'b0, len_i} - {1'b0, step};

    if (shorten) begin
      len_o = (diff_x[W] || (diff_x < lo_x)) ? lo_x[W-1:0] : diff_x[W-1:0];
    end else begin
      len_o = (sum_x > hi_x) ? hi_x[W-1:0] : sum_x[W-1:0];
    end
  end

endmodule

// File: rtl/m3_speed_ramp_calc.sv
// Motor speed ramp: decides per electrical round whether to accelerate,
// decelerate, seek a target round length, fast-stop or hold.
module m3_speed_ramp_calc
  import m3_speed_ramp_calc_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter int unsigned PERIOD_MIN = M602_PERIOD_MIN,
  parameter int unsigned PERIOD_MAX = M602_PERIOD_MAX,
  parameter int unsigned INC_SHIFT  = 4,
  parameter int unsigned DEC_SHIFT  = 4,
  parameter int unsigned STOP_SHIFT = 2,
  parameter int unsigned ROUND_MAX  = 3,
  parameter int unsigned CNT_W      = 4
) (
  input  logic         clkI,
  input  logic         nRstI,
  input  logic         workingI,
  input  logic         nextRound_1I,
  input  logic         m3speedINCi,
  input  logic         m3speedDECi,
  input  logic         m3forceStopI,
  input  logic         m3invRotateI,
  input  logic         tgtLoadI,
  input  logic [W-1:0] tgtLenI,
  input  logic         tgtClrI,
  output logic [W-1:0] dstRoundLenO,
  output logic         dirO,
  output logic [2:0]   stateO,
  output logic         stepO,
  output logic         atTargetO,
  output logic         stoppedO
);

  localparam logic [W-1:0]     P_MIN   = W'(PERIOD_MIN);
  localparam logic [W-1:0]     P_MAX   = W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] CNT_RLD = CNT_W'(ROUND_MAX);

  m3_state_e        state_q, state_d, nxt;
  logic [W-1:0]     len_q, len_d, tgt_q, tgt_d, step_len;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_act_q, tgt_act_d, dir_q, dir_d, step_q, step_d;
  step_kind_e       kind;

  m3_ramp_step #(
    .W(W), .PERIOD_MIN(PERIOD_MIN), .PERIOD_MAX(PERIOD_MAX),
    .INC_SHIFT(INC_SHIFT), .DEC_SHIFT(DEC_SHIFT), .STOP_SHIFT(STOP_SHIFT)
  ) u_step (
    .len_i  (len_q),
    .tgt_i  (tgt_q),
    .kind_i (kind),
    .len_o  (step_len)
  );

  always_comb begin
    // A direction reversal must first bring the drive to standstill.
    if (m3forceStopI || (m3invRotateI != dir_q)) nxt = ST_STOP;
    else if (m3speedINCi)                        nxt = ST_INC;
    else if (m3speedDECi)                        nxt = ST_DEC;
    else if (tgt_act_q)                          nxt = ST_SEEK;
    else                                         nxt = ST_HOLD;

    case (state_q)
      ST_INC:  kind = STEP_INC;
      ST_DEC:  kind = STEP_DEC;
      ST_STOP: kind = STEP_STOP;
      default: kind = STEP_SEEK;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    tgt_d     = tgt_q;
    tgt_act_d = tgt_act_q;
    step_d    = 1'b0;
    if (!workingI) begin
      state_d   = ST_IDLE;
      len_d     = P_MAX;
      cnt_d     = CNT_RLD;
      tgt_act_d = 1'b0;
      dir_d     = m3invRotateI;
    end else begin
      if (nextRound_1I) begin
        if (nxt != state_q) begin
          state_d = nxt;
          cnt_d   = CNT_RLD;
        end else begin
          case (state_q)
            ST_INC, ST_DEC, ST_SEEK: begin
              if (cnt_q == '0) begin
                len_d = step_len;
                cnt_d = CNT_RLD;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
            ST_STOP: len_d = step_len;
            default: cnt_d = CNT_RLD;
          endcase
        end
        if ((nxt == ST_STOP) && (len_d == P_MAX)) dir_d = m3invRotateI;
        if (m3speedINCi || m3speedDECi) tgt_act_d = 1'b0;
        step_d = (len_d != len_q);
      end
      if (tgtClrI) tgt_act_d = 1'b0;
      if (tgtLoadI) begin
        tgt_d     = (tgtLenI < P_MIN) ? P_MIN : ((tgtLenI > P_MAX) ? P_MAX : tgtLenI);
        tgt_act_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state_q   <= ST_IDLE;
      len_q     <= P_MAX;
      cnt_q     <= CNT_RLD;
      dir_q     <= 1'b0;
      tgt_q     <= P_MAX;
      tgt_act_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      tgt_q     <= tgt_d;
      tgt_act_q <= tgt_act_d;
      step_q    <= step_d;
    end
  end

  assign dstRoundLenO = len_q;
  assign dirO         = dir_q;
  assign stateO       = state_q;
  assign stepO        = step_q;
  assign atTargetO    = tgt_act_q && (len_q == tgt_q);
  assign stoppedO     = (len_q == P_MAX) && (state_q != ST_INC) && (state_q != ST_SEEK);

endmodule

// File: tb/tb_m3_speed_ramp_calc.sv
// Self-checking bench for m3_speed_ramp_calc: vector table plus scoreboarded
// ramp sequences with an independent reference of the step arithmetic.
module tb_m3_speed_ramp_calc;

  localparam int     W    = 32;
  localparam longint PMIN = 40;
  localparam longint PMAX = 1_000_000;
  localparam int S_IDLE = 0, S_HOLD = 1, S_INC = 2, S_SEEK = 4, S_STOP = 5;

  logic clk = 1'b0, rst_n = 1'b0, working = 1'b0, nr = 1'b0;
  logic inc = 1'b0, dec = 1'b0, frc = 1'b0, inv = 1'b0, tl = 1'b0, tc = 1'b0;
  logic [W-1:0] tlen = '0;
  logic [W-1:0] len_o;
  logic [2:0]   st_o;
  logic         dir_o, step_o, at_o, stop_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  m3_speed_ramp_calc dut (
    .clkI(clk), .nRstI(rst_n), .workingI(working), .nextRound_1I(nr),
    .m3speedINCi(inc), .m3speedDECi(dec), .m3forceStopI(frc), .m3invRotateI(inv),
    .tgtLoadI(tl), .tgtLenI(tlen), .tgtClrI(tc),
    .dstRoundLenO(len_o), .dirO(dir_o), .stateO(st_o), .stepO(step_o),
    .atTargetO(at_o), .stoppedO(stop_o)
  );

  typedef struct { string nm; int st; longint len; bit stp; } exp_t;
  exp_t exp_q[$];

  typedef struct { bit inc; bit dec; bit frc; int st; longint len; bit stp; } vec_t;
  vec_t vecs[15];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push(input string nm, input int st, input longint len, input bit stp);
    exp_t e;
    e.nm = nm; e.st = st; e.len = len; e.stp = stp;
    exp_q.push_back(e);
  endtask

  task automatic round_only();
    @(negedge clk); nr = 1'b1;
    @(negedge clk); nr = 1'b0;
  endtask

  task automatic round_cmp();
    exp_t e;
    round_only();
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({e.nm, "_state"}, st_o, e.st);
      chk({e.nm, "_len"}, len_o, e.len);
      chk({e.nm, "_stepO"}, step_o, e.stp);
    end
  endtask

  task automatic load_tgt(input longint v);
    @(negedge clk); tl = 1'b1; tlen = W'(v);
    @(negedge clk); tl = 1'b0;
  endtask

  function automatic longint stepsz(input longint l, input int sh);
    longint s;
    s = l >> sh;
    return (s == 0) ? 1 : s;
  endfunction

  function automatic longint ref_stop(input longint l);
    longint v;
    v = l + stepsz(l, 2);
    return (v > PMAX) ? PMAX : v;
  endfunction

  function automatic longint ref_seek(input longint l, input longint t);
    longint v;
    if (t < l) begin
      v = l - stepsz(l, 4);
      return (v < t) ? t : v;
    end else if (t > l) begin
      v = l + stepsz(l, 4);
      return (v > t) ? t : v;
    end
    return l;
  endfunction

  // Seek from a non-SEEK state: one entry round, then a step every fourth round.
  task automatic seek_run(input string nm, input longint start, input longint tgt, input int bound);
    longint m, nx;
    int k;
    bit done;
    m = start; k = 0; done = 1'b0;
    push({nm, "_entry"}, S_SEEK, m, 1'b0);
    round_cmp();
    while (!done && k < bound) begin
      k++;
      if (k % 4 == 0) begin
        nx = ref_seek(m, tgt);
        push(nm, S_SEEK, nx, nx != m);
        m = nx;
      end else begin
        push(nm, S_SEEK, m, 1'b0);
      end
      round_cmp();
      if (m == tgt) done = 1'b1;
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
    chk({nm, "_atTarget"}, at_o, 1);
    chk({nm, "_final"}, len_o, tgt);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint m;
    int n;

    for (int i = 0; i < 15; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, S_INC, 1_000_000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, S_INC,  937_500, 1'b1};
    for (int i = 5; i < 8; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, S_INC, 937_500, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, S_INC,  878_907, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, S_STOP, 878_907, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, S_INC,  878_907, 1'b0};
    for (int i = 11; i < 14; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, S_INC, 878_907, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, S_INC,  823_976, 1'b1};

    // Reset state, with inv high to show dirO is held at 0 by reset
    inv = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", st_o, S_IDLE);
    chk("rst_len", len_o, PMAX);
    chk("rst_dir", dir_o, 0);
    chk("rst_stepO", step_o, 0);
    chk("rst_atTarget", at_o, 0);
    chk("rst_stopped", stop_o, 1);
    inv = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    working = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_round_state", st_o, S_IDLE);

    // Accel ramp, then STOP/INC priority with counter reload
    for (int i = 0; i < 15; i++) begin
      inc = vecs[i].inc; dec = vecs[i].dec; frc = vecs[i].frc;
      push($sformatf("vec%0d", i), vecs[i].st, vecs[i].len, vecs[i].stp);
      round_cmp();
    end
    inc = 1'b0; dec = 1'b0; frc = 1'b0;

    @(negedge clk); working = 1'b0;
    @(negedge clk);
    chk("wk_low_state", st_o, S_IDLE);
    chk("wk_low_len", len_o, PMAX);
    chk("wk_low_stepO", step_o, 0);

    // Target seek 1_000_000 -> 500_000, then hold at the target
    working = 1'b1;
    load_tgt(500_000);
    seek_run("seek500k", PMAX, 500_000, 200);
    for (int i = 0; i < 4; i++) push("hold500k", S_SEEK, 500_000, 1'b0);
    for (int i = 0; i < 4; i++) round_cmp();

    // Retarget to 300_000, then drop workingI mid-SEEK
    load_tgt(300_000);
    n = 0;
    while (len_o != 300_000 && n < 100) begin
      round_only();
      n++;
      if (len_o < 300_000) chk("seek300k_overshoot", len_o, 300_000);
    end
    chk("seek300k_final", len_o, 300_000);
    chk("seek300k_atTarget", at_o, 1);
    @(negedge clk); working = 1'b0;
    @(negedge clk);
    chk("drop_state", st_o, S_IDLE);
    chk("drop_len", len_o, PMAX);
    chk("drop_atTarget", at_o, 0);
    working = 1'b1;
    push("after_drop", S_HOLD, PMAX, 1'b0);
    round_cmp();

    // Seek to 100_000, then reverse direction: STOP ramps +25% per round
    load_tgt(100_000);
    seek_run("seek100k", PMAX, 100_000, 400);
    inv = 1'b1;
    @(negedge clk); tc = 1'b1;
    @(negedge clk); tc = 1'b0;
    push("stop_entry", S_STOP, 100_000, 1'b0);
    round_cmp();
    chk("stop_entry_dir", dir_o, 0);
    m = 100_000;
    n = 0;
    while (m != PMAX && n < 30) begin
      m = ref_stop(m);
      push("stop", S_STOP, m, 1'b1);
      round_cmp();
      chk("stop_dir", dir_o, (m == PMAX) ? 1 : 0);
      n++;
    end
    chk("stop_reached_max", m, PMAX);
    chk("stop_stopped", stop_o, 1);
    push("post_stop", S_HOLD, PMAX, 1'b0);
    round_cmp();
    chk("post_stop_dir", dir_o, 1);
    chk("post_stop_stopped", stop_o, 1);

    // Seek to 42, then INC clamps at PERIOD_MIN and stops pulsing stepO
    load_tgt(42);
    seek_run("seek42", PMAX, 42, 1200);
    inc = 1'b1;
    for (int i = 0; i < 4; i++) push("inc42", S_INC, 42, 1'b0);
    push("inc42_clamp", S_INC, PMIN, 1'b1);
    for (int i = 0; i < 3; i++) push("inc40", S_INC, PMIN, 1'b0);
    push("inc40_noclamp_step", S_INC, PMIN, 1'b0);
    for (int i = 0; i < 9; i++) round_cmp();
    chk("inc40_atTarget", at_o, 0);
    chk("inc40_stopped", stop_o, 0);
    inc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
